// File: rtl/updown_mod_counter_pkg.sv
// Shared counter definitions: end-of-range behaviour and the load clamp.
// Timer blocks reuse these through import counter_pkg::*.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP,
        CNT_SAT
    } cnt_mode_e;

    // Out-of-range load values go to the last legal count, never past it
    function automatic int clamp_mod(input int value, input int modulus);
        return (value > modulus - 1) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Command/status bundle of the up/down modulo counter.
// No handshake: command inputs are sampled on every rising clk edge; status is always valid.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;

    modport master (
        output en, up, clear, load, load_val,
        input  count, tc, wrapped
    );

    modport slave (
        input  en, up, clear, load, load_val,
        output count, tc, wrapped
    );
endinterface

// File: rtl/updown_mod_counter_step.sv
// Combinational next-count and rollover decode for one enabled step.
// Arithmetic is WIDTH+1 bits so a full 2**WIDTH range never truncates.
module counter_step
    import counter_pkg::*;
#(
    parameter int        WIDTH   = 4,
    parameter int        MODULUS = 2 ** WIDTH,
    parameter cnt_mode_e MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next,
    output logic             roll
);

    localparam logic [WIDTH:0] MOD_W  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_W = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH:0] wide;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;
    logic           at_top;
    logic           at_bottom;

    assign wide      = {1'b0, count};
    assign inc       = wide + (WIDTH + 1)'(1);
    assign dec       = wide - (WIDTH + 1)'(1);
    // Reaching MODULUS on increment, or borrowing on decrement, marks the range end
    assign at_top    = (inc == MOD_W);
    assign at_bottom = dec[WIDTH];

    always_comb begin
        next = count;
        roll = 1'b0;
        if (up) begin
            if (!at_top) begin
                next = inc[WIDTH-1:0];
            end else if (MODE == CNT_WRAP) begin
                next = '0;
                roll = 1'b1;
            end
        end else begin
            if (!at_bottom) begin
                next = dec[WIDTH-1:0];
            end else if (MODE == CNT_WRAP) begin
                next = LAST_W[WIDTH-1:0];
                roll = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear > load > enable priority, wrap or saturate ends,
// combinational terminal count and a registered one-cycle rollover pulse.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH   = 4,
    parameter int        MODULUS = 2 ** WIDTH,
    parameter cnt_mode_e MODE    = CNT_WRAP
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_mod_counter_if.slave  bus
);

    generate
        if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic             wrapped_q;
    logic [WIDTH-1:0] step_next;
    logic             step_roll;
    logic [WIDTH-1:0] load_clamped;

    counter_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .MODE    (MODE)
    ) u_step (
        .count (count_q),
        .up    (bus.up),
        .next  (step_next),
        .roll  (step_roll)
    );

    assign load_clamped = WIDTH'(clamp_mod(int'({1'b0, bus.load_val}), MODULUS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (bus.clear) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (bus.load) begin
            count_q   <= load_clamped;
            wrapped_q <= 1'b0;
        end else if (bus.en) begin
            count_q   <= step_next;
            wrapped_q <= step_roll;
        end else begin
            wrapped_q <= 1'b0;
        end
    end

    // tc warns that the next enabled edge reaches the end, in either mode
    always_comb begin
        bus.tc = bus.en & ((bus.up & (count_q == LAST)) | (~bus.up & (count_q == '0)));
    end

    assign bus.count   = count_q;
    assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (mod 16 wrap, mod 10 wrap, mod 10 saturate)
// driven from a vector table through an expected-value queue, plus an async reset sequence.
module tb_updown_mod_counter;
    import counter_pkg::*;

    typedef struct {
        int         sel;
        logic       en;
        logic       up;
        logic       clear;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] exp_count;
        logic       exp_wrapped;
        logic       exp_tc;
        string      name;
    } vec_t;

    logic clk;
    logic rst0, rst1, rst2;
    int   tests;
    int   failed;
    logic [4:0] exp_q[$];
    vec_t vecs[$];

    updown_mod_counter_if #(.WIDTH(4)) b0 ();
    updown_mod_counter_if #(.WIDTH(4)) b1 ();
    updown_mod_counter_if #(.WIDTH(4)) b2 ();

    updown_mod_counter #(.WIDTH(4)) dut0 (
        .clk (clk), .reset (rst0), .bus (b0)
    );
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(CNT_WRAP)) dut1 (
        .clk (clk), .reset (rst1), .bus (b1)
    );
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(CNT_SAT)) dut2 (
        .clk (clk), .reset (rst2), .bus (b2)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary forced");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input int sel, input logic en, input logic up, input logic clear,
                         input logic load, input logic [3:0] lv);
        case (sel)
            0: begin b0.en = en; b0.up = up; b0.clear = clear; b0.load = load; b0.load_val = lv; end
            1: begin b1.en = en; b1.up = up; b1.clear = clear; b1.load = load; b1.load_val = lv; end
            default: begin b2.en = en; b2.up = up; b2.clear = clear; b2.load = load; b2.load_val = lv; end
        endcase
    endtask

    task automatic sample(input int sel, output logic [3:0] c, output logic w, output logic t);
        case (sel)
            0: begin c = b0.count; w = b0.wrapped; t = b0.tc; end
            1: begin c = b1.count; w = b1.wrapped; t = b1.tc; end
            default: begin c = b2.count; w = b2.wrapped; t = b2.tc; end
        endcase
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input logic en, input logic up, input logic clear,
                                input logic load, input logic [3:0] lv, input logic [3:0] c,
                                input logic w, input logic t, input string n);
        vec_t v;
        v.sel = sel; v.en = en; v.up = up; v.clear = clear; v.load = load; v.load_val = lv;
        v.exp_count = c; v.exp_wrapped = w; v.exp_tc = t; v.name = n;
        return v;
    endfunction

    // scoreboard: expectation queued when driven, popped after the edge
    task automatic run_vec(input vec_t v);
        logic [3:0] c;
        logic       w;
        logic       t;
        logic [4:0] exp;
        drive(v.sel, v.en, v.up, v.clear, v.load, v.load_val);
        #1;
        sample(v.sel, c, w, t);
        check({v.name, "_tc"}, 5'(t), 5'(v.exp_tc));
        exp_q.push_back({v.exp_wrapped, v.exp_count});
        @(posedge clk);
        #1;
        sample(v.sel, c, w, t);
        if (exp_q.size() == 0) begin
            check({v.name, "_queue"}, 5'(1), 5'(0));
        end else begin
            exp = exp_q.pop_front();
            check({v.name, "_wrapped_count"}, {w, c}, exp);
        end
    endtask

    task automatic fill_table();
        int cur;
        int nxt;
        // T1: free-run full 16-state range
        for (int k = 0; k < 17; k++) begin
            cur = k % 16;
            nxt = (k + 1) % 16;
            vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'(nxt), k == 15, cur == 15, "t1_free_run"));
        end
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd15, 4'd15, 0, 0, "m16_load15"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0,  4'd0,  1, 1, "m16_up_roll"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd0,  0, 0, "m16_idle_drop"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0,  4'd15, 1, 1, "m16_down_roll"));
        // T2: modulo 10 wrap, up then one step down
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mk(1, 1, 1, 0, 0, 4'd0, 4'((k + 1) % 10), k == 9, k == 9, "t2_up"));
        end
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd9, 1, 1, "t2_down_roll"));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd8, 0, 0, "t2_down"));
        // T4: priority and clamp
        vecs.push_back(mk(1, 1, 1, 0, 1, 4'd7,  4'd7, 0, 0, "t4_load_over_en"));
        vecs.push_back(mk(1, 1, 1, 1, 1, 4'd7,  4'd0, 0, 0, "t4_clear_wins"));
        vecs.push_back(mk(1, 0, 1, 0, 1, 4'd13, 4'd9, 0, 0, "t4_clamp13"));
        vecs.push_back(mk(1, 1, 0, 0, 1, 4'd9,  4'd9, 0, 0, "t4_load_last"));
        vecs.push_back(mk(1, 0, 1, 0, 1, 4'd15, 4'd9, 0, 0, "t4_clamp15"));
        vecs.push_back(mk(1, 1, 1, 0, 0, 4'd0,  4'd0, 1, 1, "t4_roll_from_clamp"));
        vecs.push_back(mk(1, 1, 1, 0, 1, 4'd3,  4'd3, 0, 0, "t4_load_kills_pulse"));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'd0,  4'd0, 0, 0, "t4_clear_ignores_en"));
        vecs.push_back(mk(1, 1, 1, 0, 0, 4'd0,  4'd1, 0, 0, "t4_up"));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0,  4'd0, 0, 0, "t4_dir_change"));
        vecs.push_back(mk(1, 0, 0, 0, 1, 4'd6,  4'd6, 0, 0, "t5_load6"));
        // T3: saturate
        for (int k = 0; k < 12; k++) begin
            cur = (k > 9) ? 9 : k;
            nxt = (k + 1 > 9) ? 9 : k + 1;
            vecs.push_back(mk(2, 1, 1, 0, 0, 4'd0, 4'(nxt), 0, cur == 9, "t3_sat_up"));
        end
        for (int k = 0; k < 12; k++) begin
            cur = (9 - k < 0) ? 0 : 9 - k;
            nxt = (8 - k < 0) ? 0 : 8 - k;
            vecs.push_back(mk(2, 1, 0, 0, 0, 4'd0, 4'(nxt), 0, cur == 0, "t3_sat_down"));
        end
        // T6: enable low, direction toggling
        vecs.push_back(mk(2, 0, 0, 0, 1, 4'd5, 4'd5, 0, 0, "t6_load5"));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(2, 0, k[0], 0, 0, 4'd0, 4'd5, 0, 0, "t6_hold"));
        end
        vecs.push_back(mk(2, 1, 1, 0, 0, 4'd0, 4'd6, 0, 0, "t6_up"));
        vecs.push_back(mk(2, 1, 0, 0, 0, 4'd0, 4'd5, 0, 0, "t6_down"));
    endtask

    initial begin
        logic [3:0] c;
        logic       w;
        logic       t;
        tests  = 0;
        failed = 0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 0, 0, 0, 0, 4'd0);
        fill_table();

        // reset state
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s, c, w, t);
            check("reset_count", 5'(c), 5'd0);
            check("reset_wrapped", 5'(w), 5'd0);
            check("reset_tc_idle", 5'(t), 5'd0);
        end
        drive(0, 1, 0, 0, 0, 4'd0);
        #1;
        sample(0, c, w, t);
        check("reset_tc_down", 5'(t), 5'd1);
        drive(0, 0, 0, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // T5: async reset mid-count on the mod-10 instance (sitting at 6)
        drive(1, 1, 1, 0, 0, 4'd0);
        #2;
        rst1 = 1'b0;
        #1;
        sample(1, c, w, t);
        check("t5_async_count", 5'(c), 5'd0);
        check("t5_async_wrapped", 5'(w), 5'd0);
        check("t5_async_tc_up", 5'(t), 5'd0);
        drive(1, 1, 0, 0, 0, 4'd0);
        #1;
        sample(1, c, w, t);
        check("t5_async_tc_down", 5'(t), 5'd1);
        @(posedge clk);
        #1;
        sample(1, c, w, t);
        check("t5_held_in_reset", 5'(c), 5'd0);
        rst1 = 1'b1;
        drive(1, 1, 1, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        sample(1, c, w, t);
        check("t5_resume", {w, c}, 5'd1);

        if (exp_q.size() != 0) check("queue_drained", 5'(exp_q.size()), 5'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
